mmio_intc_timer: RTL and testbench

- Memory-mapped interrupt controller and compare-match timer. It answers the CPU data-memory port (memCe/memWr/memAddr/wtData → rdData) and drives the CPU's six-bit intr input.
- Lives beside data RAM on the data bus. The top level muxes rdData with the RAM output using selHit.
- Edge-detects five external device request lines. Generates a programmable timer interrupt on line 5, ORed with the CP0 intimer output.

---
 rtl/mmio_intc_timer.sv | 129 ++++++++++++
 tb/tb_mmio_intc_timer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_intc_timer.sv
// Memory-mapped interrupt controller with a compare-match timer on line 5.
// Sits on the CPU data bus next to data RAM; the top level selects rdData with selHit.
module mmio_intc_timer #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_FF00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memCe,
  input  logic        memWr,
  input  logic [31:0] memAddr,
  input  logic [31:0] wtData,
  output logic [31:0] rdData,
  output logic        selHit,
  input  logic [4:0]  irqSrc,
  input  logic        intimer,
  output logic [5:0]  intr
);

  // Bus handshake: memCe is the only qualifier and there is no ready; every
  // access completes in the cycle it is presented (zero wait states).
  localparam logic [5:0] OFF_PEND = 6'h00;
  localparam logic [5:0] OFF_MASK = 6'h01;
  localparam logic [5:0] OFF_CNT  = 6'h02;
  localparam logic [5:0] OFF_CMP  = 6'h03;
  localparam logic [5:0] OFF_CTRL = 6'h04;
  localparam logic [5:0] OFF_RAW  = 6'h05;

  logic [4:0]  sync_q [SYNC_STAGES];
  logic [4:0]  prev_q;
  logic [5:0]  pend_q, pend_d;
  logic [5:0]  mask_q, mask_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cmp_q, cmp_d;
  logic        en_q, en_d;
  logic        ar_q, ar_d;

  logic [5:0]  w1c;
  logic [5:0]  pend_set;
  logic [4:0]  src_edge;
  logic [4:0]  raw_lvl;
  logic        match;
  logic        wr_hit;
  logic [5:0]  word_off;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^memAddr[1:0];
  assign word_off = memAddr[7:2];
  assign selHit   = memCe && (memAddr[31:8] == BASE_ADDR[31:8]);
  assign wr_hit   = selHit && memWr;
  assign raw_lvl  = sync_q[SYNC_STAGES-1];
  assign src_edge = raw_lvl & ~prev_q;
  assign match    = en_q && (cnt_q == cmp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      pend_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      cmp_q  <= 32'hFFFF_FFFF;
      en_q   <= 1'b0;
      ar_q   <= 1'b0;
    end else begin
      sync_q[0] <= irqSrc;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= raw_lvl;
      pend_q <= pend_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      cmp_q  <= cmp_d;
      en_q   <= en_d;
      ar_q   <= ar_d;
    end
  end

  always_comb begin
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    en_d     = en_q;
    ar_d     = ar_q;
    w1c      = '0;
    pend_set = {match, src_edge};

    if (en_q) begin
      if (match) begin
        if (ar_q) cnt_d = '0;
        else      en_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end

    // Bus writes come last so they override timer updates; the match itself
    // was already decided from the old CMP/CTRL.
    if (wr_hit) begin
      case (word_off)
        OFF_PEND: w1c         = wtData[5:0];
        OFF_MASK: mask_d      = wtData[5:0];
        OFF_CNT:  cnt_d       = wtData;
        OFF_CMP:  cmp_d       = wtData;
        OFF_CTRL: {ar_d, en_d} = wtData[1:0];
        default: ;
      endcase
    end

    pend_d = (pend_q & ~w1c) | pend_set;
  end

  always_comb begin
    rdData = '0;
    if (selHit && !memWr) begin
      case (word_off)
        OFF_PEND: rdData = {26'b0, pend_q};
        OFF_MASK: rdData = {26'b0, mask_q};
        OFF_CNT:  rdData = cnt_q;
        OFF_CMP:  rdData = cmp_q;
        OFF_CTRL: rdData = {30'b0, ar_q, en_q};
        OFF_RAW:  rdData = {27'b0, raw_lvl};
        default:  rdData = '0;
      endcase
    end
  end

  assign intr = {(pend_q[5] & mask_q[5]) | intimer, pend_q[4:0] & mask_q[4:0]};

endmodule

// File: tb/tb_mmio_intc_timer.sv
// Testbench for mmio_intc_timer: directed scenarios plus random traffic,
// checked against a cycle-level behavioural model through an expected-read queue.
module tb_mmio_intc_timer;

  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam int          SYNC = 2;

  logic        clk = 1'b0;
  logic        rst, memCe, memWr, selHit, intimer;
  logic [31:0] memAddr, wtData, rdData;
  logic [4:0]  irqSrc;
  logic [5:0]  intr;

  mmio_intc_timer #(.BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .memCe(memCe), .memWr(memWr), .memAddr(memAddr),
    .wtData(wtData), .rdData(rdData), .selHit(selHit), .irqSrc(irqSrc),
    .intimer(intimer), .intr(intr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // ---------------- reference model ----------------
  // m_hist[k] is irqSrc as sampled k rising edges ago (0 after a reset).
  logic [5:0]  m_pend, m_mask;
  logic [31:0] m_cnt, m_cmp;
  logic        m_en, m_ar;
  logic [4:0]  m_hist [SYNC+2];

  task automatic model_step();
    logic [5:0]  set, clr;
    logic [31:0] cnt_n;
    logic        en_n, ar_n, hit;
    if (rst) begin
      m_pend = 0; m_mask = 0; m_cnt = 0; m_cmp = 32'hFFFF_FFFF; m_en = 0; m_ar = 0;
      for (int k = 0; k < SYNC + 2; k++) m_hist[k] = 0;
      return;
    end
    for (int k = SYNC + 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irqSrc;
    set = {1'b0, m_hist[SYNC] & ~m_hist[SYNC+1]};
    cnt_n = m_cnt; en_n = m_en; ar_n = m_ar; clr = 0;
    if (m_en) begin
      if (m_cnt == m_cmp) begin
        set[5] = 1'b1;
        if (m_ar) cnt_n = 0;
        else      en_n = 0;
      end else begin
        cnt_n = m_cnt + 1;
      end
    end
    hit = memCe && memWr && (memAddr[31:8] == BASE[31:8]);
    if (hit) begin
      case (memAddr[7:0] & 8'hFC)
        8'h00: clr = wtData[5:0];
        8'h04: m_mask = wtData[5:0];
        8'h08: cnt_n = wtData;
        8'h0C: m_cmp = wtData;
        8'h10: begin en_n = wtData[0]; ar_n = wtData[1]; end
        default: ;
      endcase
    end
    m_cnt = cnt_n; m_en = en_n; m_ar = ar_n;
    m_pend = (m_pend & ~clr) | set;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    if (addr[31:8] != BASE[31:8]) return 0;
    case (addr[7:0] & 8'hFC)
      8'h00:   return {26'b0, m_pend};
      8'h04:   return {26'b0, m_mask};
      8'h08:   return m_cnt;
      8'h0C:   return m_cmp;
      8'h10:   return {30'b0, m_ar, m_en};
      8'h14:   return {27'b0, m_hist[SYNC-1]};
      default: return 0;
    endcase
  endfunction

  always @(posedge clk) model_step();

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [5:0] exp_intr;
    exp_intr = {(m_pend[5] & m_mask[5]) | intimer, m_pend[4:0] & m_mask[4:0]};
    check("intr", {26'b0, intr}, {26'b0, exp_intr});
    check("selHit", {31'b0, selHit}, {31'b0, memCe && (memAddr[31:8] == BASE[31:8])});
    if (memCe && !memWr) begin
      if (exp_q.size() == 0) check("rd_queue_empty", 32'd1, 32'd0);
      else check("rdData", rdData, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle_end();
    @(posedge clk); #1;
    memCe = 0; memWr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle_end();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    memCe = 1; memWr = 1; memAddr = addr; wtData = data;
    cycle_end();
  endtask

  task automatic rd(input logic [31:0] addr);
    memCe = 1; memWr = 0; memAddr = addr;
    exp_q.push_back(model_read(addr));
    cycle_end();
  endtask

  // Read whose expected value is a fixed constant rather than the model's.
  task automatic rd_exp(input logic [31:0] addr, input logic [31:0] exp);
    memCe = 1; memWr = 0; memAddr = addr;
    exp_q.push_back(exp);
    cycle_end();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1; memCe = 0; memWr = 0; memAddr = 0; wtData = 0; irqSrc = 0; intimer = 0;
    idle(3);
    rst = 0;

    // Reset state
    rd_exp(BASE + 32'h00, 32'h0);
    rd_exp(BASE + 32'h04, 32'h0);
    rd_exp(BASE + 32'h08, 32'h0);
    rd_exp(BASE + 32'h0C, 32'hFFFF_FFFF);
    rd_exp(BASE + 32'h10, 32'h0);
    idle(2);

    // One-cycle pulse on irqSrc[2]: PEND appears 3 cycles after the rise
    wr(BASE + 32'h04, 32'h3F);
    irqSrc = 5'h04;
    idle(1);
    irqSrc = 5'h00;
    rd_exp(BASE + 32'h00, 32'h0);
    rd_exp(BASE + 32'h00, 32'h0);
    rd_exp(BASE + 32'h00, 32'h4);
    wr(BASE + 32'h00, 32'h4);
    rd_exp(BASE + 32'h00, 32'h0);
    // Held level: sets once, no re-set after clearing
    irqSrc = 5'h04;
    idle(4);
    rd_exp(BASE + 32'h00, 32'h4);
    wr(BASE + 32'h00, 32'h4);
    idle(6);
    rd_exp(BASE + 32'h00, 32'h0);
    rd_exp(BASE + 32'h14, 32'h4);
    irqSrc = 5'h00;
    idle(4);

    // Auto-reload timer, CMP=5
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h0C, 32'h5);
    wr(BASE + 32'h10, 32'h3);
    for (int i = 0; i < 14; i++) rd_exp(BASE + 32'h08, (i % 6));
    rd(BASE + 32'h00);
    // One-shot timer stops at CMP and clears EN
    wr(BASE + 32'h10, 32'h0);
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h00, 32'h20);
    wr(BASE + 32'h10, 32'h1);
    for (int i = 0; i < 10; i++) rd_exp(BASE + 32'h08, (i < 5) ? i : 5);
    rd_exp(BASE + 32'h10, 32'h0);
    rd_exp(BASE + 32'h00, 32'h20);

    // Edge set and W1C of the same bit in the same cycle: set wins
    wr(BASE + 32'h00, 32'h3F);
    irqSrc = 5'h01;
    idle(2);
    wr(BASE + 32'h00, 32'h1);
    rd_exp(BASE + 32'h00, 32'h1);
    irqSrc = 5'h00;

    // CNT write at an auto-reload match: written value wins, PEND[5] still set
    wr(BASE + 32'h00, 32'h3F);
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h10, 32'h3);
    for (int i = 0; i < 5; i++) rd_exp(BASE + 32'h08, i);
    wr(BASE + 32'h08, 32'd100);
    rd_exp(BASE + 32'h08, 32'd100);
    rd_exp(BASE + 32'h00, 32'h20);
    wr(BASE + 32'h10, 32'h0);

    // Masked pending lines, intimer bypass, holes and out-of-window accesses
    wr(BASE + 32'h04, 32'h0);
    irqSrc = 5'h1F;
    idle(1);
    irqSrc = 5'h00;
    wr(BASE + 32'h08, 32'h0);
    wr(BASE + 32'h0C, 32'h2);
    wr(BASE + 32'h10, 32'h1);
    idle(6);
    rd_exp(BASE + 32'h00, 32'h3F);
    intimer = 1;
    idle(2);
    intimer = 0;
    rd_exp(BASE + 32'h40, 32'h0);
    wr(BASE + 32'h104, 32'h3F);
    rd_exp(BASE + 32'h04, 32'h0);
    rd_exp(BASE + 32'h100, 32'h0);

    // Reset while the timer runs with everything pending
    wr(BASE + 32'h04, 32'h3F);
    wr(BASE + 32'h0C, 32'hFFFF_FFF0);
    wr(BASE + 32'h10, 32'h3);
    idle(3);
    rst = 1;
    idle(1);
    rst = 0;
    rd_exp(BASE + 32'h00, 32'h0);
    rd_exp(BASE + 32'h04, 32'h0);
    rd_exp(BASE + 32'h08, 32'h0);
    rd_exp(BASE + 32'h0C, 32'hFFFF_FFFF);
    rd_exp(BASE + 32'h10, 32'h0);

    // Random traffic
    for (int it = 0; it < 600; it++) begin
      logic [31:0] off, data;
      int op;
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 7) == 0) irqSrc[b] = ~irqSrc[b];
      intimer = ($urandom_range(0, 5) == 0);
      off = 4 * $urandom_range(0, 7);
      if (off == 32'h1C) off = 32'h40;
      case (off)
        32'h08, 32'h0C: data = $urandom_range(0, 30);
        32'h10:         data = $urandom_range(0, 3);
        default:        data = $urandom;
      endcase
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1; idle(1); rst = 0;
      end else if (op <= 3) begin
        rd(BASE + off);
      end else if (op <= 6) begin
        wr(BASE + off, data);
      end else if (op == 7) begin
        memCe = 0; memWr = 1; memAddr = BASE + off; wtData = data;
        cycle_end();
      end else if (op == 8) begin
        if ($urandom_range(0, 1) == 0) rd(BASE + 32'h100 + off);
        else wr(BASE + 32'h100 + off, data);
      end else begin
        idle(1);
      end
    end

    irqSrc = 0; intimer = 0;
    idle(2);
    check("rd_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
